rv32: RTL and testbench
=======================

# rv32

Multi-cycle RV32I integer core (RV32 subset) with separate instruction and data buses. It fetches 32-bit instructions through a word-addressed instruction port and executes loads and stores through a byte-addressed data port. It is the top-level CPU datapath plus control; the instruction and data memories are external.

## Interface
- No parameters.
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  asynchronous, active-low reset
- instr_data_i  in  32  instruction word at `instr_addr_o`, valid one cycle after the address
- mem_data_i  in  32  read data at `mem_addr_o`, valid one cycle after the address
- instr_addr_o  out  32  instruction word index (PC >> 2)
- mem_we_o  out  1  data write strobe, one cycle per store
- mem_addr_o  out  32  data byte address; word aligned (bits [1:0] forced to 0)
- mem_data_o  out  32  store data

## Operation
- 32 x 32 register file; x0 reads 0, writes to x0 ignored. PC is a byte address.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target bit 0 cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW and SW only.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Other load/store widths, FENCE, SYSTEM, undefined opcodes and 0x00000000 execute as NOP (PC += 4, no register or memory update).
- Immediates are sign-extended per the RV32I I/S/B/U/J formats.
- Shift amount is rs2[4:0] or imm[4:0].
- All arithmetic is 32-bit modulo 2^32; no traps or exceptions.
- Misaligned jump or branch targets are not checked; PC advances as computed.
- State machine, reset to FETCH:
  - FETCH: drive `instr_addr_o` = PC[31:2]; go to DECODE.
  - DECODE: capture `instr_data_i` into the instruction register (IR); go to EXEC.
  - EXEC, non-memory instruction: write rd and update PC (PC+4, branch/jump target); go to FETCH.
  - EXEC, LW/SW: register `mem_addr_o` = (rs1+imm) & ~3. For SW also register `mem_data_o` = rs2 and `mem_we_o` = 1. Go to MEM.
  - MEM: `mem_we_o` is high during this cycle for SW only. SW: clear `mem_we_o`, PC += 4, go to FETCH. LW: go to WB.
  - WB: rd <= `mem_data_i`, PC += 4; go to FETCH.

## Timing
- Reset values (asynchronous, while `rst_i` = 0): PC = 0, state = FETCH, IR = 0, all registers 0, `instr_addr_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0, `mem_we_o` = 0.
- First fetch is at word 0 on the first rising edge after `rst_i` rises.
- Cycles per instruction: ALU/branch/jump/LUI/AUIPC 3, SW 4, LW 5.
- `instr_addr_o` is stable from FETCH through EXEC. `mem_addr_o` is held through MEM and WB.
- Load data is sampled at the end of WB, two edges after `mem_addr_o` becomes valid, so a one-cycle-latency memory is tolerated.
- `mem_we_o` is asserted for exactly one clock per SW and never during reset.
- Register read-after-write is safe: the write completes before the next DECODE.
- Reset mid-instruction aborts it: no partial writes, and `mem_we_o` drops immediately.

## Structure
- Shared package `rv32_pkg`:
  - opcode constants (LOAD, STORE, OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH);
  - funct3/funct7 constants;
  - state enum {FETCH, DECODE, EXEC, MEM, WB};
  - ALU operation enum.
- One natural sub-module: `rv32_alu`, purely combinational (a, b, alu_op -> result, plus branch compare flags).
- Register file, immediate generation and the FSM stay in the top module.

## Test plan
- Data word at byte 64 = 3; program: lw x1,64(x0); addi x2,x1,123; addi x3,x2,51; andi x3,x3,63; sw x3,64(x0). Required result: x1=3, x2=126, x3=49, and memory[64] = 49 after the store. Exactly one `mem_we_o` pulse with `mem_addr_o` = 64.
- Reset low mid-execution: all outputs go to 0 immediately. After release, fetch restarts at word 0 and registers read 0.
- addi x0,x0,5 then add x1,x0,x0: x1 = 0.
- Branch test: beq taken (offset +8) skips the next instruction; bne not taken falls through. blt -1 vs 1 is taken; bltu 0xFFFFFFFF vs 1 is not taken.
- jal x1,+16 at PC 8: x1 = 12, next `instr_addr_o` = 6. jalr x0,x1,1 jumps to byte 12 (bit 0 cleared).
- Instruction 0x00000000 and unsupported lb: PC advances by 4, no register write, `mem_we_o` stays 0. Check cycle counts: addi = 3, sw = 4, lw = 5.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: opcodes, funct fields, FSM states and ALU ops shared by the rv32 core
package rv32_pkg;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    localparam logic [2:0] F3_W    = 3'd2;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    // alt selects SUB/SRA; caller decides when funct7 bit 5 is meaningful
    function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
        return f3 == F3_ADD  ? (alt ? ALU_SUB : ALU_ADD) :
               f3 == F3_SLL  ? ALU_SLL :
               f3 == F3_SLT  ? ALU_SLT :
               f3 == F3_SLTU ? ALU_SLTU :
               f3 == F3_XOR  ? ALU_XOR :
               f3 == F3_SR   ? (alt ? ALU_SRA : ALU_SRL) :
               f3 == F3_OR   ? ALU_OR : ALU_AND;
    endfunction
endpackage

// File: rtl/rv32_alu.sv
// rv32_alu: combinational integer ALU with branch compare flags
module rv32_alu
    import rv32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);
    assign eq  = a == b;
    assign lt  = $signed(a) < $signed(b);
    assign ltu = a < b;

    always_comb begin
        result = a + b;
        case (alu_op)
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, lt};
            ALU_SLTU: result = {31'b0, ltu};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = 32'($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = a + b;
        endcase
    end
endmodule

// File: rtl/rv32.sv
// rv32: multi-cycle RV32I subset core, FETCH/DECODE/EXEC(/MEM/WB) per instruction
module rv32
    import rv32_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_data_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] instr_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o
);
    state_t      state;
    logic [31:0] pc, ir;
    logic [31:0] rf [32];

    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v, alu_b, alu_res, pc4, rd_val, next_pc, ls_addr;
    logic        eq, lt, ltu, taken, rd_we, is_lw, is_sw;
    alu_op_t     alu_op;

    assign opc = ir[6:0];
    assign rd  = ir[11:7];
    assign f3  = ir[14:12];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // x0 is never written, so a plain read returns 0 for it
    assign rs1_v = rf[rs1];
    assign rs2_v = rf[rs2];

    assign alu_b  = (opc == OPC_OP || opc == OPC_BRANCH) ? rs2_v : imm_i;
    assign alu_op = alu_decode(f3, opc == OPC_OP ? ir[30] : (f3 == F3_SR && ir[30]));

    rv32_alu u_alu (
        .a      (rs1_v),
        .b      (alu_b),
        .alu_op (alu_op),
        .result (alu_res),
        .eq     (eq),
        .lt     (lt),
        .ltu    (ltu)
    );

    assign taken = f3 == F3_BEQ  ? eq  :
                   f3 == F3_BNE  ? !eq :
                   f3 == F3_BLT  ? lt  :
                   f3 == F3_BGE  ? !lt :
                   f3 == F3_BLTU ? ltu :
                   f3 == F3_BGEU ? !ltu : 1'b0;

    assign pc4     = pc + 32'd4;
    assign is_lw   = opc == OPC_LOAD && f3 == F3_W;
    assign is_sw   = opc == OPC_STORE && f3 == F3_W;
    assign ls_addr = (rs1_v + (opc == OPC_STORE ? imm_s : imm_i)) & ~32'd3;
    assign rd_we   = rd != 5'd0 &&
                     opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM};
    assign rd_val  = opc == OPC_LUI   ? imm_u :
                     opc == OPC_AUIPC ? pc + imm_u :
                     (opc == OPC_JAL || opc == OPC_JALR) ? pc4 : alu_res;
    assign next_pc = opc == OPC_JAL  ? pc + imm_j :
                     opc == OPC_JALR ? (rs1_v + imm_i) & ~32'd1 :
                     (opc == OPC_BRANCH && taken) ? pc + imm_b : pc4;

    assign instr_addr_o = {2'b0, pc[31:2]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= FETCH;
            pc         <= '0;
            ir         <= '0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_we_o   <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    ir    <= instr_data_i;
                    state <= EXEC;
                end
                EXEC: begin
                    if (is_lw || is_sw) begin
                        mem_addr_o <= ls_addr;
                        if (is_sw) begin
                            mem_data_o <= rs2_v;
                            mem_we_o   <= 1'b1;
                        end
                        state <= MEM;
                    end else begin
                        if (rd_we) rf[rd] <= rd_val;
                        pc    <= next_pc;
                        state <= FETCH;
                    end
                end
                MEM: begin
                    mem_we_o <= 1'b0;
                    if (is_sw) begin
                        pc    <= pc4;
                        state <= FETCH;
                    end else begin
                        state <= WB;
                    end
                end
                WB: begin
                    if (rd != 5'd0) rf[rd] <= mem_data_i;
                    pc    <= pc4;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32.sv
// tb_rv32: runs small programs on rv32 and scoreboards every store it makes
module tb_rv32;
    logic        clk = 0, rst_n = 0;
    logic [31:0] instr_data, mem_rdata, instr_addr, mem_addr, mem_wdata;
    logic        mem_we;
    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic [31:0] sb_a [$];
    logic [31:0] sb_d [$];
    int          arr [64];
    int          cyc = 0, n_chk = 0, n_err = 0;
    logic [31:0] last_ia = 0;
    logic        we_last = 0;

    rv32 dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .instr_data_i (instr_data),
        .mem_data_i   (mem_rdata),
        .instr_addr_o (instr_addr),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        instr_data <= imem[instr_addr[5:0]];
        if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= dmem[mem_addr[7:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (sb_a.size() == 0) check("sw_unexpected", mem_addr, 32'hFFFF_FFFF);
            else begin
                check("sw_addr", mem_addr, sb_a.pop_front());
                check("sw_data", mem_wdata, sb_d.pop_front());
            end
            check("we_width", {31'b0, we_last}, 32'd0);
        end
        we_last = mem_we;
    end

    // cycle on which each instruction word was first addressed since reset
    always @(negedge clk) begin
        if (!rst_n) begin
            foreach (arr[i]) arr[i] = -1;
            last_ia = 0;
        end else if (instr_addr != last_ia) begin
            arr[instr_addr[5:0]] = cyc;
            last_ia = instr_addr;
        end
    end

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_sw(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm[31:12], rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    task automatic expect_st(input logic [31:0] a, input logic [31:0] d);
        sb_a.push_back(a);
        sb_d.push_back(d);
    endtask

    task automatic reset_and_clear();
        @(negedge clk);
        rst_n = 0;
        foreach (imem[i]) imem[i] = 0;
        foreach (dmem[i]) dmem[i] = 0;
        sb_a.delete();
        sb_d.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input string tag);
        int n = 0;
        rst_n = 1;
        while (sb_a.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check(tag, sb_a.size(), 32'd0);
        repeat (20) @(posedge clk);
    endtask

    task automatic load_prog1();
        dmem[16] = 32'd3;
        imem[0] = enc_i(64, 0, 3'd2, 1, 7'h03);
        imem[1] = enc_i(123, 1, 3'd0, 2, 7'h13);
        imem[2] = enc_i(51, 2, 3'd0, 3, 7'h13);
        imem[3] = enc_i(63, 3, 3'd7, 3, 7'h13);
        imem[4] = enc_sw(64, 3, 0);
        imem[5] = enc_sw(68, 1, 0);
        imem[6] = enc_sw(72, 2, 0);
        imem[7] = enc_j(0, 0);
    endtask

    logic [4:0]  p3_reg [12] = '{10, 11, 12, 13, 14, 15, 16, 17, 19, 20, 21, 22};
    logic [31:0] p3_val [12] = '{32'd0, 32'd2, 32'd0, 32'd4, 32'h1234_5000, 32'h0000_102C,
                                 32'd2, 32'hF800_0000, 32'h4000_0000, 32'd1, 32'd0, 32'hFFFF_FFFE};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_addr", instr_addr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_wdata, 0);
        check("rst_mem_we", {31'b0, mem_we}, 0);

        // lw/addi/andi/sw dependency chain
        reset_and_clear();
        load_prog1();
        expect_st(64, 49);
        expect_st(68, 3);
        expect_st(72, 126);
        run("p1_done");
        check("p1_mem64", dmem[16], 49);

        // x0 writes, NOPs, cycle counts
        reset_and_clear();
        dmem[16] = 32'd77;
        imem[0]  = enc_i(5, 0, 3'd0, 0, 7'h13);
        imem[1]  = enc_r(0, 0, 0, 3'd0, 1);
        imem[2]  = enc_i(1, 0, 3'd0, 7, 7'h13);
        imem[3]  = 32'h0;
        imem[4]  = enc_i(64, 0, 3'd0, 5, 7'h03);
        imem[5]  = enc_sw(80, 1, 0);
        imem[6]  = enc_sw(84, 5, 0);
        imem[7]  = enc_i(64, 0, 3'd2, 6, 7'h03);
        imem[8]  = enc_sw(88, 6, 0);
        imem[9]  = enc_sw(92, 7, 0);
        imem[10] = enc_j(0, 0);
        expect_st(80, 0);
        expect_st(84, 0);
        expect_st(88, 77);
        expect_st(92, 1);
        run("p2_done");
        check("cpi_addi", arr[3] - arr[2], 3);
        check("cpi_nop0", arr[4] - arr[3], 3);
        check("cpi_lb", arr[5] - arr[4], 3);
        check("cpi_sw", arr[6] - arr[5], 4);
        check("cpi_lw", arr[8] - arr[7], 5);
        check("p2_lb_nowrite", dmem[16], 77);

        // branches, LUI/AUIPC, ALU ops
        reset_and_clear();
        imem[0]  = enc_i(-1, 0, 3'd0, 1, 7'h13);
        imem[1]  = enc_i(1, 0, 3'd0, 2, 7'h13);
        imem[2]  = enc_b(8, 0, 0, 3'd0);
        imem[3]  = enc_i(1, 0, 3'd0, 10, 7'h13);
        imem[4]  = enc_b(8, 0, 0, 3'd1);
        imem[5]  = enc_i(2, 0, 3'd0, 11, 7'h13);
        imem[6]  = enc_b(8, 2, 1, 3'd4);
        imem[7]  = enc_i(3, 0, 3'd0, 12, 7'h13);
        imem[8]  = enc_b(8, 2, 1, 3'd6);
        imem[9]  = enc_i(4, 0, 3'd0, 13, 7'h13);
        imem[10] = enc_u(32'h1234_5000, 14, 7'h37);
        imem[11] = enc_u(32'h0000_1000, 15, 7'h17);
        imem[12] = enc_r(7'h20, 1, 2, 3'd0, 16);
        imem[13] = enc_i(31, 2, 3'd1, 18, 7'h13);
        imem[14] = enc_i(32'h404, 18, 3'd5, 17, 7'h13);
        imem[15] = enc_r(0, 2, 18, 3'd5, 19);
        imem[16] = enc_r(0, 2, 1, 3'd2, 20);
        imem[17] = enc_r(0, 2, 1, 3'd3, 21);
        imem[18] = enc_r(0, 2, 1, 3'd4, 22);
        for (int i = 0; i < 12; i++) begin
            imem[19 + i] = enc_sw(128 + 4 * i, p3_reg[i], 0);
            expect_st(128 + 4 * i, p3_val[i]);
        end
        imem[31] = enc_j(0, 0);
        run("p3_done");

        // jal / jalr with odd target
        reset_and_clear();
        imem[0] = enc_i(0, 0, 3'd0, 5, 7'h13);
        imem[1] = enc_i(9, 0, 3'd0, 6, 7'h13);
        imem[2] = enc_j(16, 1);
        imem[3] = enc_sw(120, 6, 0);
        imem[4] = enc_j(0, 0);
        imem[5] = enc_i(99, 0, 3'd0, 6, 7'h13);
        imem[6] = enc_sw(112, 1, 0);
        imem[7] = enc_i(1, 1, 3'd0, 0, 7'h67);
        expect_st(112, 12);
        expect_st(120, 9);
        run("p4_done");
        check("jal_next", arr[6] - arr[2], 3);
        check("jal_skip", arr[5], 32'hFFFF_FFFF);
        check("jalr_next", arr[3] - arr[7], 3);

        // reset asserted while a store is in MEM
        reset_and_clear();
        load_prog1();
        rst_n = 1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (mem_we) break;
        end
        check("abort_we_seen", {31'b0, mem_we}, 1);
        check("abort_pre_addr", mem_addr, 64);
        rst_n = 0;
        #1;
        check("abort_instr_addr", instr_addr, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_mem_data", mem_wdata, 0);
        check("abort_mem_we", {31'b0, mem_we}, 0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_write", dmem[16], 3);
        @(negedge clk);
        foreach (imem[i]) imem[i] = 0;
        imem[0] = enc_sw(0, 1, 0);
        imem[1] = enc_sw(4, 2, 0);
        imem[2] = enc_sw(8, 3, 0);
        imem[3] = enc_j(0, 0);
        expect_st(0, 0);
        expect_st(4, 0);
        expect_st(8, 0);
        run("p5_done");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
